// File: rtl/fifo1_pkg.sv
// Shared defaults and width helpers for the fifo1 write-side adapter.
package fifo1_pkg;

  localparam int DSIZE_DEF  = 8;
  localparam int BDEPTH_DEF = 4;

  // Ceiling log2, usable in constant expressions for pointer widths.
  function automatic int fifo1_clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return res;
  endfunction

  localparam int PTR_W_DEF = fifo1_clog2(BDEPTH_DEF);
  localparam int LVL_W_DEF = PTR_W_DEF + 1;

endpackage

// File: rtl/fifo1_wr_buf.sv
// Elastic buffer for the write adapter: register-array storage, wrapping
// pointers, occupancy level and two combinational read ports (head and the
// entry behind it) so the caller can look past a word it is about to pop.
module fifo1_wr_buf
  import fifo1_pkg::*;
#(
  parameter  int DSIZE  = DSIZE_DEF,
  parameter  int BDEPTH = BDEPTH_DEF,
  localparam int PTR_W  = fifo1_clog2(BDEPTH),
  localparam int LVL_W  = PTR_W + 1
) (
  input  logic             wclk2x,
  input  logic             wrst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [DSIZE-1:0] wdata,
  output logic [DSIZE-1:0] head,
  output logic [DSIZE-1:0] next_head,
  output logic [LVL_W-1:0] level
);

  logic [DSIZE-1:0] mem [BDEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_ptr_nxt;

  assign rd_ptr_nxt = rd_ptr + PTR_W'(1);
  assign head       = mem[rd_ptr];
  assign next_head  = mem[rd_ptr_nxt];

  // Storage is not reset; stale contents are unreachable once pointers clear.
  always_ff @(posedge wclk2x) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally (BDEPTH is a power of 2); level tracks push - pop.
  always_ff @(posedge wclk2x or negedge wrst_n) begin
    if (!wrst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr_nxt;
      end
      level <= level + LVL_W'(push) - LVL_W'(pop);
    end
  end

endmodule

// File: rtl/fifo1_wr_adapter.sv
// Write-side front end of fifo1_sram in the wclk2x domain. Buffers a
// valid/ready byte stream and paces it into wdata_in/winc: wdata_in only
// moves on P-edges (wphase=1) and winc only on M-edges, so the FIFO's
// mid-period pre-register always sees a settled word and wfull is
// re-checked half a wclk before every write.
module fifo1_wr_adapter
  import fifo1_pkg::*;
#(
  parameter  int DSIZE  = DSIZE_DEF,
  parameter  int BDEPTH = BDEPTH_DEF,
  localparam int PTR_W  = fifo1_clog2(BDEPTH),
  localparam int LVL_W  = PTR_W + 1
) (
  input  logic             wclk2x,
  input  logic             wrst_n,
  input  logic             wphase,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DSIZE-1:0] in_data,
  input  logic             wfull,
  output logic             winc,
  output logic [DSIZE-1:0] wdata_in,
  output logic [LVL_W-1:0] level
);

  logic             push;
  logic             pop;
  logic             hv;
  logic             head_ok;
  logic [DSIZE-1:0] head;
  logic [DSIZE-1:0] next_head;
  logic [DSIZE-1:0] head_sel;

  // Ready comes from the registered level only, never from in_valid.
  assign in_ready = (level != LVL_W'(BDEPTH));
  assign push     = in_valid & in_ready;
  // winc only lands in the FIFO at a wclk edge, i.e. a P-edge.
  assign pop      = wphase & winc;

  fifo1_wr_buf #(
    .DSIZE  (DSIZE),
    .BDEPTH (BDEPTH)
  ) u_buf (
    .wclk2x    (wclk2x),
    .wrst_n    (wrst_n),
    .push      (push),
    .pop       (pop),
    .wdata     (in_data),
    .head      (head),
    .next_head (next_head),
    .level     (level)
  );

  // Post-pop head from pre-edge state; a same-edge push is deliberately not seen.
  always_comb begin
    head_sel = head;
    head_ok  = (level >= LVL_W'(1));
    if (pop) begin
      head_sel = next_head;
      head_ok  = (level >= LVL_W'(2));
    end
  end

  // P-edges load the next word and head-valid; M-edges decide winc from wfull.
  always_ff @(posedge wclk2x or negedge wrst_n) begin
    if (!wrst_n) begin
      winc     <= 1'b0;
      wdata_in <= '0;
      hv       <= 1'b0;
    end else if (wphase) begin
      if (head_ok) begin
        wdata_in <= head_sel;
        hv       <= 1'b1;
      end else begin
        hv       <= 1'b0;
      end
    end else begin
      winc <= hv & ~wfull;
    end
  end

endmodule

// File: tb/tb_fifo1_wr_adapter.sv
// Bench for fifo1_wr_adapter: a per-edge vector table for the single-word,
// two-word and one-wclk wfull cases, then hand-written streaming, full-stall,
// mid-run reset and random end-to-end sequences against a small FIFO model.
module tb_fifo1_wr_adapter;

  localparam int DSIZE  = 8;
  localparam int BDEPTH = 4;
  localparam int LVL_W  = 3;
  localparam int MDEPTH = 4;

  logic             wclk2x;
  logic             wrst_n;
  logic             wphase;
  logic             in_valid;
  logic             in_ready;
  logic [DSIZE-1:0] in_data;
  logic             wfull;
  logic             winc;
  logic [DSIZE-1:0] wdata_in;
  logic [LVL_W-1:0] level;

  logic wfull_drv;
  logic use_model;
  logic model_full = 1'b0;
  logic rinc       = 1'b0;
  logic ph_prev    = 1'b0;
  logic ph_seen    = 1'b0;

  int tests      = 0;
  int fails      = 0;
  int pcnt       = 0;
  int viol_full  = 0;
  int viol_phase = 0;
  int full_seen  = 0;

  logic [DSIZE-1:0] wr_q [$];
  logic [DSIZE-1:0] mem_q [$];
  logic [DSIZE-1:0] rd_q [$];
  logic [DSIZE-1:0] sent [$];
  int               wr_t [$];

  typedef struct {
    logic             vld;
    logic [DSIZE-1:0] din;
    logic             full;
    logic             e_winc;
    logic [DSIZE-1:0] e_wdata;
    logic [LVL_W-1:0] e_level;
    logic             e_ready;
  } vec_t;

  vec_t vecs [18];

  assign wfull = use_model ? model_full : wfull_drv;

  fifo1_wr_adapter #(
    .DSIZE  (DSIZE),
    .BDEPTH (BDEPTH)
  ) dut (
    .wclk2x   (wclk2x),
    .wrst_n   (wrst_n),
    .wphase   (wphase),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .wfull    (wfull),
    .winc     (winc),
    .wdata_in (wdata_in),
    .level    (level)
  );

  initial wclk2x = 1'b0;
  always #5 wclk2x = ~wclk2x;

  // wphase: 1 while in reset so the first edge after release is a P-edge.
  always @(posedge wclk2x or negedge wrst_n) begin
    if (!wrst_n) begin
      wphase = 1'b1;
    end else begin
      #1;
      wphase = ~wphase;
    end
  end

  // FIFO-side monitor: phase alternation, no write while full, write log, model FIFO.
  always @(posedge wclk2x) begin
    if (wrst_n) begin
      assert (!ph_seen || (wphase != ph_prev)) else begin
        viol_phase++;
        $display("FAIL wphase_alt: wphase=%0b on two consecutive edges", wphase);
      end
      ph_prev = wphase;
      ph_seen = 1'b1;
      if (wphase) begin
        pcnt++;
        assert (!(winc && wfull)) else begin
          viol_full++;
          $display("FAIL write_when_full: winc=1 with wfull=1 at P-edge %0d", pcnt);
        end
        if (wfull) full_seen++;
        if (winc && !wfull) begin
          wr_q.push_back(wdata_in);
          wr_t.push_back(pcnt);
          if (use_model) mem_q.push_back(wdata_in);
        end
        if (use_model) begin
          rinc = 1'($urandom_range(0, 1));
          if (rinc && (mem_q.size() > 0)) rd_q.push_back(mem_q.pop_front());
          model_full <= (mem_q.size() >= MDEPTH);
        end else begin
          model_full <= 1'b0;
        end
      end
    end else begin
      ph_seen = 1'b0;
      model_full <= 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge wclk2x);
    #2;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] wr_at(input int i);
    return (i < wr_q.size()) ? 32'(wr_q[i]) : 32'hDEAD_BEEF;
  endfunction

  task automatic clear_logs();
    wr_q.delete();
    wr_t.delete();
  endtask

  initial begin
    int idx;
    int bad;
    int p0;
    int lvl_max;
    int rdy_low;
    logic [DSIZE-1:0] seq;

    //          vld   din    full   winc  wdata  lvl   rdy
    vecs = '{
      '{1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 3'd1, 1'b1},  // E0 P push A5
      '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 3'd1, 1'b1},  // E1 M
      '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 3'd1, 1'b1},  // E2 P load
      '{1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 3'd1, 1'b1},  // E3 M winc up
      '{1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 3'd0, 1'b1},  // E4 P write A5
      '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 3'd0, 1'b1},  // E5 M winc down
      '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 3'd0, 1'b1},  // E6 P
      '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 3'd0, 1'b1},  // E7 M
      '{1'b1, 8'h11, 1'b0, 1'b0, 8'hA5, 3'd1, 1'b1},  // E8 P push 11
      '{1'b1, 8'h22, 1'b0, 1'b0, 8'hA5, 3'd2, 1'b1},  // E9 M push 22
      '{1'b0, 8'h00, 1'b0, 1'b0, 8'h11, 3'd2, 1'b1},  // E10 P load 11
      '{1'b0, 8'h00, 1'b0, 1'b1, 8'h11, 3'd2, 1'b1},  // E11 M
      '{1'b0, 8'h00, 1'b0, 1'b1, 8'h22, 3'd1, 1'b1},  // E12 P write 11, load 22
      '{1'b0, 8'h00, 1'b1, 1'b0, 8'h22, 3'd1, 1'b1},  // E13 M wfull
      '{1'b0, 8'h00, 1'b1, 1'b0, 8'h22, 3'd1, 1'b1},  // E14 P no write
      '{1'b0, 8'h00, 1'b0, 1'b1, 8'h22, 3'd1, 1'b1},  // E15 M wfull clear
      '{1'b0, 8'h00, 1'b0, 1'b1, 8'h22, 3'd0, 1'b1},  // E16 P write 22
      '{1'b0, 8'h00, 1'b0, 1'b0, 8'h22, 3'd0, 1'b1}   // E17 M
    };

    wrst_n    = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    wfull_drv = 1'b0;
    use_model = 1'b0;
    #1;
    wrst_n = 1'b0;
    #1;
    check("reset_winc",     32'(winc),     32'd0);
    check("reset_wdata",    32'(wdata_in), 32'd0);
    check("reset_level",    32'(level),    32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    step();
    step();
    wrst_n = 1'b1;

    // Per-edge table: single word, two words, one wclk of wfull.
    for (int i = 0; i < 18; i++) begin
      in_valid  = vecs[i].vld;
      in_data   = vecs[i].din;
      wfull_drv = vecs[i].full;
      step();
      check($sformatf("vec%0d_winc", i),     32'(winc),     32'(vecs[i].e_winc));
      check($sformatf("vec%0d_wdata", i),    32'(wdata_in), 32'(vecs[i].e_wdata));
      check($sformatf("vec%0d_level", i),    32'(level),    32'(vecs[i].e_level));
      check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_ready));
    end
    in_valid  = 1'b0;
    wfull_drv = 1'b0;
    check("vec_writes_count", 32'(wr_q.size()), 32'd3);
    check("vec_write0", wr_at(0), 32'hA5);
    check("vec_write1", wr_at(1), 32'h11);
    check("vec_write2", wr_at(2), 32'h22);

    // Streaming: one push per wclk on P-edges.
    clear_logs();
    if (!wphase) step();
    lvl_max = 0;
    rdy_low = 0;
    for (int i = 0; i < 64; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      if (!in_ready) rdy_low++;
      step();
      if (int'(level) > lvl_max) lvl_max = int'(level);
      in_valid = 1'b0;
      if (!in_ready) rdy_low++;
      step();
      if (int'(level) > lvl_max) lvl_max = int'(level);
    end
    for (int i = 0; i < 12; i++) step();
    check("stream_count", 32'(wr_q.size()), 32'd64);
    bad = 0;
    for (int i = 0; i < 64; i++) if (wr_at(i) != 32'(i)) bad++;
    check("stream_order_errors", 32'(bad), 32'd0);
    bad = 0;
    for (int i = 1; i < wr_t.size(); i++) if (wr_t[i] - wr_t[i-1] != 1) bad++;
    check("stream_rate_gaps", 32'(bad), 32'd0);
    check("stream_level_le2", 32'(lvl_max <= 2), 32'd1);
    check("stream_ready_low", 32'(rdy_low), 32'd0);

    // Full stall: wfull high while pushing 0x10..0x17.
    clear_logs();
    if (wphase) step();
    wfull_drv = 1'b1;
    idx = 0;
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      in_data  = 8'h10 + 8'(idx);
      if (in_ready) idx++;
      step();
    end
    check("stall_level",    32'(level),       32'd4);
    check("stall_in_ready", 32'(in_ready),    32'd0);
    check("stall_winc",     32'(winc),        32'd0);
    check("stall_wdata",    32'(wdata_in),    32'h10);
    check("stall_no_write", 32'(wr_q.size()), 32'd0);
    if (wphase) step();
    wfull_drv = 1'b0;
    for (int k = 0; k < 100 && idx < 8; k++) begin
      in_valid = 1'b1;
      in_data  = 8'h10 + 8'(idx);
      if (in_ready) idx++;
      step();
    end
    in_valid = 1'b0;
    check("stall_all_pushed", 32'(idx), 32'd8);
    for (int k = 0; k < 20; k++) step();
    check("stall_count", 32'(wr_q.size()), 32'd8);
    bad = 0;
    for (int i = 0; i < 8; i++) if (wr_at(i) != 32'h10 + 32'(i)) bad++;
    check("stall_order_errors", 32'(bad), 32'd0);

    // Mid-run reset with three words held back by wfull.
    clear_logs();
    if (wphase) step();
    wfull_drv = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data  = 8'hA0 + 8'(k);
      step();
    end
    in_valid = 1'b0;
    check("pre_reset_level", 32'(level), 32'd3);
    wrst_n = 1'b0;
    #1;
    check("midreset_winc",     32'(winc),     32'd0);
    check("midreset_wdata",    32'(wdata_in), 32'd0);
    check("midreset_level",    32'(level),    32'd0);
    check("midreset_in_ready", 32'(in_ready), 32'd1);
    wfull_drv = 1'b0;
    step();
    step();
    wrst_n   = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h5A;
    step();
    in_valid = 1'b0;
    p0 = pcnt;
    for (int k = 0; k < 6; k++) step();
    check("postreset_count", 32'(wr_q.size()), 32'd1);
    check("postreset_word",  wr_at(0),         32'h5A);
    check("postreset_edge",  32'((wr_t.size() > 0) ? wr_t[0] - p0 : -1), 32'd2);

    // Random end-to-end through a small FIFO model with random reads.
    clear_logs();
    use_model = 1'b1;
    seq = '0;
    for (int k = 0; k < 1500; k++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = seq;
      if (in_valid && in_ready) begin
        sent.push_back(seq);
        seq = seq + 8'd1;
      end
      step();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 600 && rd_q.size() < sent.size(); k++) step();
    check("e2e_count", 32'(rd_q.size()), 32'(sent.size()));
    bad = 0;
    for (int i = 0; i < sent.size(); i++) begin
      if (i >= rd_q.size()) bad++;
      else if (rd_q[i] != sent[i]) bad++;
    end
    check("e2e_data_errors", 32'(bad), 32'd0);
    check("e2e_full_hit", 32'(full_seen > 0), 32'd1);
    check("no_write_when_full", 32'(viol_full), 32'd0);
    check("wphase_alternates",  32'(viol_phase), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
